// File: rtl/pc_pkg.sv
// Shared types and helpers for the IF-stage program-counter controller.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    FAULT = 2'd3
  } pc_state_t;

  localparam int unsigned INSTR_BYTES_DEF = 4;
  localparam int unsigned ALIGN_BITS      = $clog2(INSTR_BYTES_DEF);

  // Mask that clears the low align_bits bits of an address.
  function automatic logic [63:0] align_mask(input int unsigned align_bits = ALIGN_BITS);
    return ~((64'd1 << align_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect target with valid bit; consume wins over load.
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              consume_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic              pend_o,
  output logic [ADDR_W-1:0] target_o
);

  logic              vld_p0;
  logic [ADDR_W-1:0] tgt_p0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p0 <= 1'b0;
    end else if (consume_i) begin
      vld_p0 <= 1'b0;
    end else if (load_i) begin
      vld_p0 <= 1'b1;
    end
  end

  // Target payload needs no reset; it is only observed while vld_p0 is set.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      tgt_p0 <= target_i;
    end
  end

  assign pend_o   = vld_p0;
  assign target_o = tgt_p0;

endmodule

// File: rtl/pc_ctrl.sv
// IF-stage program-counter controller: increment, stall, redirect, buffered redirect.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] TRAP_PC     = ADDR_W'(32'h0000_0080)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hd_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_o,
  output logic              valid_o,
  output logic              pend_o,
  output logic              fault_o
);

`ifdef PC_ALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask($clog2(INSTR_BYTES)));

  pc_state_t         state_p0;
  logic [ADDR_W-1:0] pc_p0;
  logic              fault_p0;

  logic              ld_en;
  logic [ADDR_W-1:0] ld_tgt;
  logic              buf_load;
  logic              buf_consume;
  logic [ADDR_W-1:0] buf_tgt;
  logic              fault_now;
  logic              inc_en;

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (buf_load),
    .consume_i (buf_consume),
    .target_i  (redirect_pc_i),
    .pend_o    (pend_o),
    .target_o  (buf_tgt)
  );

  always_comb begin
    ld_en       = 1'b0;
    ld_tgt      = redirect_pc_i;
    buf_load    = 1'b0;
    buf_consume = 1'b0;
    inc_en      = 1'b0;
    unique case (state_p0)
      IDLE: ld_en = redirect_i;
      RUN: begin
        if (!start_i) begin
          ld_en = redirect_i;
        end else if (redirect_i) begin
          ld_en    = !hd_i;
          buf_load = hd_i;
        end else begin
          inc_en = !hd_i;
        end
      end
      PEND: begin
        // A redirect arriving on the release edge is newer than the buffered one.
        ld_tgt = redirect_i ? redirect_pc_i : buf_tgt;
        if (!start_i || !hd_i) begin
          ld_en       = 1'b1;
          buf_consume = 1'b1;
        end else begin
          buf_load = redirect_i;
        end
      end
      FAULT: ;
    endcase
  end

  assign fault_now = CHECK_EN && ld_en && (|(ld_tgt & ~ALIGN_MASK));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_p0 <= IDLE;
      pc_p0    <= RESET_PC;
      fault_p0 <= 1'b0;
    end else if (fault_now) begin
      state_p0 <= FAULT;
      pc_p0    <= TRAP_PC;
      fault_p0 <= 1'b1;
    end else begin
      if (ld_en) begin
        pc_p0 <= ld_tgt & ALIGN_MASK;
      end else if (inc_en) begin
        pc_p0 <= pc_plus_o;
      end
      unique case (state_p0)
        IDLE:    state_p0 <= start_i ? RUN : IDLE;
        RUN:     state_p0 <= !start_i ? IDLE : ((redirect_i && hd_i) ? PEND : RUN);
        PEND:    state_p0 <= !start_i ? IDLE : (!hd_i ? RUN : PEND);
        FAULT:   state_p0 <= FAULT;
      endcase
    end
  end

  assign pc_o      = pc_p0;
  assign pc_plus_o = pc_p0 + ADDR_W'(INSTR_BYTES);
  assign valid_o   = (state_p0 == RUN) && !hd_i && !pend_o;
  assign fault_o   = fault_p0;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed table-driven bench for pc_ctrl with default parameters.
module tb_pc_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        hd_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_o;
  logic        valid_o;
  logic        pend_o;
  logic        fault_o;

  int n_chk  = 0;
  int n_fail = 0;

  pc_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .hd_i          (hd_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .pc_plus_o     (pc_plus_o),
    .valid_o       (valid_o),
    .pend_o        (pend_o),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start;
    logic        hd;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_pend;
    logic        exp_fault;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic h, input logic r, input logic [31:0] t,
                     input logic [31:0] pc, input logic v, input logic p, input logic f);
    vec_t e;
    e.start = s; e.hd = h; e.redir = r; e.tgt = t;
    e.exp_pc = pc; e.exp_valid = v; e.exp_pend = p; e.exp_fault = f;
    vq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic r, input logic [31:0] t);
    start_i = s; hd_i = h; redirect_i = r; redirect_pc_i = t;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   start hd redir tgt            pc             valid pend fault
    add(1, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0004, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0008, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_000C, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0010, 1, 0, 0);
    add(1, 1, 0, 32'h0,         32'h0000_0010, 0, 0, 0);
    add(1, 1, 0, 32'h0,         32'h0000_0010, 0, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0014, 1, 0, 0);
    add(1, 1, 1, 32'h200,       32'h0000_0014, 0, 1, 0);
    add(1, 1, 0, 32'h0,         32'h0000_0014, 0, 1, 0);
    add(1, 1, 0, 32'h0,         32'h0000_0014, 0, 1, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0200, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0204, 1, 0, 0);
    add(1, 1, 1, 32'h200,       32'h0000_0204, 0, 1, 0);
    add(1, 1, 1, 32'h300,       32'h0000_0204, 0, 1, 0);
    add(1, 1, 0, 32'h0,         32'h0000_0204, 0, 1, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0300, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0304, 1, 0, 0);
    add(1, 0, 1, 32'h1000,      32'h0000_1000, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_1004, 1, 0, 0);
    add(1, 1, 1, 32'h400,       32'h0000_1004, 0, 1, 0);
    add(1, 0, 1, 32'h500,       32'h0000_0500, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0504, 1, 0, 0);
    add(1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0004, 1, 0, 0);
    add(0, 0, 0, 32'h0,         32'h0000_0004, 0, 0, 0);
    add(0, 0, 1, 32'h40,        32'h0000_0040, 0, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0040, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0044, 1, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    add(1, 0, 1, 32'h102,       32'h0000_0080, 0, 0, 1);
    add(1, 0, 0, 32'h0,         32'h0000_0080, 0, 0, 1);
    add(1, 0, 1, 32'h20,        32'h0000_0080, 0, 0, 1);
`else
    add(1, 0, 1, 32'h102,       32'h0000_0100, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0000_0104, 1, 0, 0);
    add(1, 0, 1, 32'h20,        32'h0000_0020, 1, 0, 0);
`endif

    // Reset state, checked without any clock edge having been seen.
    rst_i = 1'b0;
    drive(0, 0, 0, 32'h0);
    #2;
    chk("reset_pc",    pc_o,    32'h0);
    chk("reset_valid", 32'(valid_o), 32'h0);
    chk("reset_pend",  32'(pend_o),  32'h0);
    chk("reset_fault", 32'(fault_o), 32'h0);
    chk("reset_plus",  pc_plus_o, 32'h4);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].hd, vq[i].redir, vq[i].tgt);
      tick();
      chk($sformatf("v%0d_pc", i),    pc_o,             vq[i].exp_pc);
      chk($sformatf("v%0d_valid", i), 32'(valid_o),     32'(vq[i].exp_valid));
      chk($sformatf("v%0d_pend", i),  32'(pend_o),      32'(vq[i].exp_pend));
      chk($sformatf("v%0d_fault", i), 32'(fault_o),     32'(vq[i].exp_fault));
      chk($sformatf("v%0d_plus", i),  pc_plus_o,        vq[i].exp_pc + 32'd4);
    end

    // Asynchronous reset in the middle of a pending redirect.
    rst_i = 1'b0;
    #2;
    rst_i = 1'b1;
    drive(1, 0, 0, 32'h0);
    tick();
    chk("seq_a_run_pc", pc_o, 32'h0);
    drive(1, 1, 1, 32'h200);
    tick();
    chk("seq_a_pend", 32'(pend_o), 32'h1);
    drive(1, 1, 0, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    chk("seq_a_async_pc",    pc_o,            32'h0);
    chk("seq_a_async_pend",  32'(pend_o),     32'h0);
    chk("seq_a_async_valid", 32'(valid_o),    32'h0);
    chk("seq_a_async_fault", 32'(fault_o),    32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1, 0, 0, 32'h0);
    tick();
    chk("seq_a_restart_pc", pc_o, 32'h0);
    tick();
    chk("seq_a_discard_pc", pc_o, 32'h4);

    // Dropping start_i while a redirect is buffered applies it and idles.
    drive(1, 1, 1, 32'h600);
    tick();
    chk("seq_b_pend", 32'(pend_o), 32'h1);
    drive(0, 1, 0, 32'h0);
    tick();
    chk("seq_b_idle_pc",    pc_o,         32'h600);
    chk("seq_b_idle_pend",  32'(pend_o),  32'h0);
    chk("seq_b_idle_valid", 32'(valid_o), 32'h0);
    drive(0, 0, 0, 32'h0);
    tick();
    chk("seq_b_hold_pc", pc_o, 32'h600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
